// File: rtl/index_reg_sequencer.sv
// index_reg_sequencer: sequences the 65C02 X/Y index registers for
// LDX/LDY/INX/INY/DEX/DEY/TAX/TAY/TSX. It takes a decoded opcode, waits for a
// bus operand where the opcode needs one, and issues one load/inc/dec strobe.
// It then reports N/Z to the status register. CPU RDY low freezes the sequencer.
// Optional build macro: INDEX_FLAG_BYPASS_EN. When defined, there is no FLAGS
// state. N/Z are computed from the value being written and reported together
// with the strobe, which makes every operation one cycle shorter.
module index_reg_sequencer #(
    parameter int DATA_W       = 8,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [7:0]        opcode,
    input  logic              rdy,
    input  logic              db_valid,
    input  logic [DATA_W-1:0] db_in,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] s_in,
    input  logic [DATA_W-1:0] x_q,
    input  logic [DATA_W-1:0] y_q,
    output logic              x_load,
    output logic              x_inc,
    output logic              x_dec,
    output logic              y_load,
    output logic              y_inc,
    output logic              y_dec,
    output logic [DATA_W-1:0] x_data,
    output logic [DATA_W-1:0] y_data,
    output logic              flag_we,
    output logic              flag_n,
    output logic              flag_z,
    output logic              done,
    output logic              err,
    output logic              busy
);

    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_WAIT_OPERAND = 2'd1;
    localparam logic [1:0] S_WRITE        = 2'd2;
    localparam logic [1:0] S_FLAGS        = 2'd3;

    localparam logic [1:0] K_LOAD = 2'd0;
    localparam logic [1:0] K_INC  = 2'd1;
    localparam logic [1:0] K_DEC  = 2'd2;

    localparam logic [1:0] SRC_BUS = 2'd0;
    localparam logic [1:0] SRC_A   = 2'd1;
    localparam logic [1:0] SRC_S   = 2'd2;

    // LDX/LDY in immediate, zero-page and absolute forms; the operand comes from the bus.
    function automatic logic is_operand_op(input logic [7:0] op);
        return op inside {8'hA2, 8'hA6, 8'hAE, 8'hA0, 8'hA4, 8'hAC};
    endfunction

    function automatic logic is_supported(input logic [7:0] op);
        return is_operand_op(op) ||
               (op inside {8'hE8, 8'hCA, 8'hC8, 8'h88, 8'hAA, 8'hA8, 8'hBA});
    endfunction

    logic [1:0]        r_state;
    logic [7:0]        r_wait_cnt;
    logic [7:0]        r_opcode;
    logic [DATA_W-1:0] r_operand;
    logic              r_err_pulse;

    logic              w_accept;
    logic              w_wait_last;
    logic              w_tgt_y;
    logic [1:0]        w_kind;
    logic [1:0]        w_src;
    logic [DATA_W-1:0] w_load_val;
    logic [DATA_W-1:0] w_tgt_q;
    logic              w_strobe;
    logic              w_flag_fire;
    logic [DATA_W-1:0] w_flag_val;

    assign w_accept    = op_valid & op_ready;
    assign w_wait_last = (r_wait_cnt == 8'(MEM_WAIT_MAX - 1));

    // Decode the latched opcode into a target register, an operation and a load source.
    always_comb begin
        // NOTE: each output gets a default before the case, so an unlisted opcode cannot infer a latch.
        w_tgt_y = 1'b0;
        w_kind  = K_LOAD;
        w_src   = SRC_BUS;
        case (r_opcode)
            8'hA0, 8'hA4, 8'hAC: w_tgt_y = 1'b1;
            8'hE8:               w_kind  = K_INC;
            8'hCA:               w_kind  = K_DEC;
            8'hC8:               begin w_tgt_y = 1'b1; w_kind = K_INC; end
            8'h88:               begin w_tgt_y = 1'b1; w_kind = K_DEC; end
            8'hAA:               w_src   = SRC_A;
            8'hA8:               begin w_tgt_y = 1'b1; w_src = SRC_A; end
            8'hBA:               w_src   = SRC_S;
            default:             ;
        endcase
    end

    assign w_load_val = (w_src == SRC_A) ? a_in :
                        (w_src == SRC_S) ? s_in : r_operand;
    assign w_tgt_q    = w_tgt_y ? y_q : x_q;
    assign w_strobe   = (r_state == S_WRITE) & rdy;

`ifdef INDEX_FLAG_BYPASS_EN
    // Predict the written value so that N/Z can be reported together with the strobe.
    always_comb begin
        w_flag_val = w_load_val;
        if (w_kind == K_INC) begin
            w_flag_val = w_tgt_q + DATA_W'(1);
        end else if (w_kind == K_DEC) begin
            w_flag_val = w_tgt_q - DATA_W'(1);
        end
    end
    assign w_flag_fire = w_strobe;
`else
    assign w_flag_val  = w_tgt_q;
    assign w_flag_fire = (r_state == S_FLAGS) & rdy;
`endif

    // FSM, operand capture and wait timeout. Nothing advances while rdy is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_opcode    <= '0;
            r_operand   <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments, so every branch reads the pre-edge values.
            r_err_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_opcode   <= opcode;
                        r_wait_cnt <= '0;
                        if (!is_supported(opcode)) begin
                            r_err_pulse <= 1'b1;
                        end else if (is_operand_op(opcode)) begin
                            r_state <= S_WAIT_OPERAND;
                        end else begin
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WAIT_OPERAND: begin
                    if (rdy) begin
                        if (db_valid) begin
                            r_operand <= db_in;
                            r_state   <= S_WRITE;
                        end else if (w_wait_last) begin
                            r_wait_cnt  <= '0;
                            r_err_pulse <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 8'd1;
                        end
                    end
                end
                S_WRITE: begin
                    if (rdy) begin
`ifdef INDEX_FLAG_BYPASS_EN
                        r_state <= S_IDLE;
`else
                        r_state <= S_FLAGS;
`endif
                    end
                end
                S_FLAGS: begin
                    if (rdy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign op_ready = (r_state == S_IDLE) & rdy;
    assign busy     = (r_state != S_IDLE);

    assign x_load = w_strobe & ~w_tgt_y & (w_kind == K_LOAD);
    assign x_inc  = w_strobe & ~w_tgt_y & (w_kind == K_INC);
    assign x_dec  = w_strobe & ~w_tgt_y & (w_kind == K_DEC);
    assign y_load = w_strobe &  w_tgt_y & (w_kind == K_LOAD);
    assign y_inc  = w_strobe &  w_tgt_y & (w_kind == K_INC);
    assign y_dec  = w_strobe &  w_tgt_y & (w_kind == K_DEC);

    assign x_data = x_load ? w_load_val : '0;
    assign y_data = y_load ? w_load_val : '0;

    assign flag_we = w_flag_fire;
    assign flag_n  = w_flag_fire & w_flag_val[DATA_W-1];
    assign flag_z  = w_flag_fire & (w_flag_val == '0);
    assign done    = w_flag_fire | r_err_pulse;
    assign err     = r_err_pulse;

endmodule

// File: tb/tb_index_reg_sequencer.sv
// Self-checking bench for index_reg_sequencer. It models the X/Y register blocks,
// which are driven by the strobes and feed x_q/y_q. It predicts each operation
// from the opcode semantics and compares the outcome of every transaction.
module tb_index_reg_sequencer;

    localparam int MAX = 15;
`ifdef INDEX_FLAG_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [7:0] opcode = 8'h00;
    logic       rdy = 1'b1;
    logic       db_valid = 1'b0;
    logic [7:0] db_in = 8'h00;
    logic [7:0] a_in = 8'h00;
    logic [7:0] s_in = 8'h00;
    logic [7:0] x_q, y_q;
    logic       x_load, x_inc, x_dec, y_load, y_inc, y_dec;
    logic [7:0] x_data, y_data;
    logic       flag_we, flag_n, flag_z, done, err, busy;

    logic [7:0] xr, yr;
    logic       pre_en = 1'b0;
    logic [7:0] pre_x = 8'h00;
    logic [7:0] pre_y = 8'h00;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    index_reg_sequencer #(.DATA_W(8), .MEM_WAIT_MAX(MAX)) dut (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .rdy(rdy), .db_valid(db_valid), .db_in(db_in),
        .a_in(a_in), .s_in(s_in), .x_q(x_q), .y_q(y_q),
        .x_load(x_load), .x_inc(x_inc), .x_dec(x_dec),
        .y_load(y_load), .y_inc(y_inc), .y_dec(y_dec),
        .x_data(x_data), .y_data(y_data),
        .flag_we(flag_we), .flag_n(flag_n), .flag_z(flag_z),
        .done(done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    // X/Y register blocks: a preload port plus the strobe-driven updates.
    always @(posedge clk) begin
        if (pre_en) begin
            xr <= pre_x;
            yr <= pre_y;
        end else begin
            if (x_load)     xr <= x_data;
            else if (x_inc) xr <= xr + 8'd1;
            else if (x_dec) xr <= xr - 8'd1;
            if (y_load)     yr <= y_data;
            else if (y_inc) yr <= yr + 8'd1;
            else if (y_dec) yr <= yr - 8'd1;
        end
    end
    assign x_q = xr;
    assign y_q = yr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural meaning of each opcode: kind 0=load, 1=inc, 2=dec.
    task automatic model(input logic [7:0] op, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] a, input logic [7:0] s, input logic [7:0] d,
                         output bit sup, output bit opnd, output bit tgt_y,
                         output int kind, output logic [7:0] res);
        sup = 1; opnd = 0; tgt_y = 0; kind = 0; res = 8'h00;
        case (op)
            8'hA2, 8'hA6, 8'hAE: begin opnd = 1; res = d; end
            8'hA0, 8'hA4, 8'hAC: begin opnd = 1; tgt_y = 1; res = d; end
            8'hE8: begin kind = 1; res = x + 8'd1; end
            8'hCA: begin kind = 2; res = x - 8'd1; end
            8'hC8: begin tgt_y = 1; kind = 1; res = y + 8'd1; end
            8'h88: begin tgt_y = 1; kind = 2; res = y - 8'd1; end
            8'hAA: res = a;
            8'hA8: begin tgt_y = 1; res = a; end
            8'hBA: res = s;
            default: sup = 0;
        endcase
    endtask

    // One full transaction. db_after is the number of rdy-high wait cycles before
    // db_valid is presented (>= MAX means never). rdy is forced low for cycles
    // stall_at..stall_at+stall_len-1 after accept. A latency argument of -1 skips that check.
    task automatic run_op(input logic [7:0] op, input logic [7:0] x0, input logic [7:0] y0,
                          input logic [7:0] d, input logic [7:0] a_v, input logic [7:0] s_v,
                          input int db_after, input int rdy_pct, input int stall_at,
                          input int stall_len, input int exp_str_cyc, input int exp_done_cyc);
        bit sup, opnd, tgty, exp_err, accepted, captured, done_seen, err_seen, bad;
        int kind, cyc, hi_wait, n_str, n_flag, str_cyc, done_cyc, ns;
        logic [7:0] res, ex, ey;
        logic [5:0] str_code, exp_code;
        logic fn, fz;
        string t;

        op_valid = 0; rdy = 1; db_valid = 0;
        pre_x = x0; pre_y = y0; pre_en = 1;
        @(posedge clk); #1;
        pre_en = 0;
        model(op, x0, y0, a_v, s_v, d, sup, opnd, tgty, kind, res);
        exp_err = !sup || (opnd && db_after >= MAX);
        exp_code = exp_err ? 6'b0 : (6'b100000 >> (kind + 3 * int'(tgty)));
        a_in = a_v; s_in = s_v;
        accepted = 0; captured = 0; done_seen = 0; err_seen = 0; bad = 0;
        cyc = 0; hi_wait = 0; n_str = 0; n_flag = 0; str_cyc = -1; done_cyc = -1;
        str_code = 6'b0; fn = 1'bx; fz = 1'bx;

        for (int it = 0; it < 400 && !done_seen; it++) begin
            if (!accepted) begin
                op_valid = 1; opcode = op;
                rdy = ($urandom_range(99) < rdy_pct);
                db_valid = 1'($urandom_range(1)); db_in = 8'($urandom);
            end else begin
                op_valid = 0; opcode = 8'($urandom);
                if (cyc + 1 >= stall_at && cyc + 1 < stall_at + stall_len) rdy = 0;
                else rdy = ($urandom_range(99) < rdy_pct);
                if (opnd && !captured) begin
                    db_in = 8'($urandom);
                    db_valid = rdy ? 1'b0 : 1'($urandom_range(1));
                    if (rdy && db_after < MAX && hi_wait == db_after) begin
                        db_valid = 1; db_in = d; captured = 1;
                    end else if (rdy) begin
                        hi_wait++;
                    end
                end else begin
                    db_valid = 1'($urandom_range(1)); db_in = 8'($urandom);
                end
            end
            @(negedge clk);
            if (accepted) begin
                cyc++;
                ns = $countones({x_load, x_inc, x_dec, y_load, y_inc, y_dec});
                if (ns > 1) bad = 1;
                if (!rdy && (ns != 0 || flag_we)) bad = 1;
                if (!x_load && x_data !== 8'h00) bad = 1;
                if (!y_load && y_data !== 8'h00) bad = 1;
                if (op_ready !== (rdy && !busy)) bad = 1;
                if (ns > 0) begin
                    n_str += ns; str_cyc = cyc;
                    str_code = {x_load, x_inc, x_dec, y_load, y_inc, y_dec};
                end
                if (flag_we) begin n_flag++; fn = flag_n; fz = flag_z; end
                if (done) begin done_seen = 1; err_seen = err; done_cyc = cyc; end
                else if (err) bad = 1;
            end else if (op_valid && op_ready) begin
                accepted = 1;
            end
            if (!done_seen) begin
                @(posedge clk); #1;
            end
        end

        t = $sformatf("op%02h", op);
        check({t, " done seen"}, 32'(done_seen), 32'd1);
        check({t, " err"}, 32'(err_seen), 32'(exp_err));
        check({t, " strobe count"}, 32'(n_str), exp_err ? 32'd0 : 32'd1);
        check({t, " strobe kind"}, 32'(str_code), 32'(exp_code));
        check({t, " flag_we count"}, 32'(n_flag), exp_err ? 32'd0 : 32'd1);
        if (!exp_err) begin
            check({t, " flag_n"}, 32'(fn), 32'(res[7]));
            check({t, " flag_z"}, 32'(fz), 32'(res == 8'h00));
        end
        check({t, " cycle invariants"}, 32'(bad), 32'd0);
        if (exp_str_cyc >= 0) check({t, " strobe cycle"}, 32'(str_cyc), 32'(exp_str_cyc));
        if (exp_done_cyc >= 0) check({t, " done cycle"}, 32'(done_cyc), 32'(exp_done_cyc));

        // One idle cycle: the sequencer must be back in IDLE with the register written.
        op_valid = 0; rdy = 1; db_valid = 1'($urandom_range(1)); db_in = 8'($urandom);
        @(posedge clk); #1;
        @(negedge clk);
        ex = (!exp_err && !tgty) ? res : x0;
        ey = (!exp_err && tgty) ? res : y0;
        check({t, " x after"}, 32'(xr), 32'(ex));
        check({t, " y after"}, 32'(yr), 32'(ey));
        check({t, " idle after"},
              32'({busy, op_ready, done, err, flag_we, x_load, x_inc, x_dec, y_load, y_inc, y_dec}),
              32'h200);
        @(posedge clk); #1;
    endtask

    logic [7:0] ops [13] = '{8'hA2, 8'hA6, 8'hAE, 8'hA0, 8'hA4, 8'hAC,
                             8'hE8, 8'hCA, 8'hC8, 8'h88, 8'hAA, 8'hA8, 8'hBA};

    initial begin
        logic [7:0] rop;
        int dbw;

        // Reset state: only op_ready (= rdy) is high.
        #2;
        check("reset outputs",
              32'({op_ready, busy, done, err, flag_we, flag_n, flag_z,
                   x_load, x_inc, x_dec, y_load, y_inc, y_dec}), 32'h1000);
        check("reset data", 32'({x_data, y_data}), 32'h0);
        #20;
        @(negedge clk) reset_n = 1;
        @(posedge clk); #1;

        // Directed cases.
        run_op(8'hE8, 8'hFF, 8'h12, 8'h00, 8'h00, 8'h00, 0, 100, 0, 0, 1, 2 - BYP);
        run_op(8'hA2, 8'h33, 8'h44, 8'h80, 8'h00, 8'h00, 2, 100, 0, 0, 4, 5 - BYP);
        run_op(8'hA8, 8'h55, 8'h66, 8'h00, 8'h00, 8'h00, 0, 100, 1, 3, 4, 5 - BYP);
        run_op(8'hAC, 8'h10, 8'h20, 8'h99, 8'h00, 8'h00, MAX, 100, 0, 0, -1, MAX + 1);
        run_op(8'hEA, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 0, 100, 0, 0, -1, 1);
        run_op(8'h88, 8'h77, 8'h01, 8'h00, 8'h00, 8'h00, 0, 100, 0, 0, 1, 2 - BYP);
        run_op(8'hCA, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 0, 100, 0, 0, 1, 2 - BYP);
        run_op(8'hC8, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 0, 100, 0, 0, 1, 2 - BYP);
        run_op(8'hBA, 8'h00, 8'h00, 8'h00, 8'h12, 8'hFD, 0, 100, 0, 0, 1, 2 - BYP);

        // Reset asserted in the middle of WAIT_OPERAND.
        op_valid = 1; opcode = 8'hAE; rdy = 1; db_valid = 0;
        @(posedge clk); #1;
        op_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("wait busy", 32'(busy), 32'd1);
        #2 reset_n = 0;
        #1;
        check("mid-wait reset outputs",
              32'({op_ready, busy, done, err, flag_we, flag_n, flag_z,
                   x_load, x_inc, x_dec, y_load, y_inc, y_dec}), 32'h1000);
        check("mid-wait reset data", 32'({x_data, y_data}), 32'h0);
        @(negedge clk) reset_n = 1;
        @(posedge clk); #1;
        // A fresh wait counter admits an operand on the last permitted cycle.
        run_op(8'hAE, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, MAX - 1, 100, 0, 0, MAX + 1, MAX + 2 - BYP);

        // Randomized operations with random rdy stalls.
        for (int i = 0; i < 40; i++) begin
            rop = ($urandom_range(5) == 0) ? 8'($urandom) : ops[$urandom_range(12)];
            dbw = ($urandom_range(7) == 0) ? MAX + 1 : $urandom_range(MAX - 1);
            run_op(rop, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                   dbw, 50 + $urandom_range(50), 0, 0, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
